// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO write/read pointer blocks.
// Functions operate on PTR_MAXW-bit values; narrower pointers are zero-extended.
package fifo_ptr_pkg;

   localparam int unsigned PTR_MAXW = 17;

   typedef logic [PTR_MAXW-1:0] ptr_t;

   function automatic int unsigned fifo_depth(input int unsigned asize);
      return 32'd1 << asize;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Leading zeros from zero-extension leave the prefix XOR unaffected.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAXW-1] = g[PTR_MAXW-1];
      for (int i = PTR_MAXW-2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/gray2bin_comb.sv
// Combinational Gray-to-binary converter of width W.
// Shared by the write- and read-side pointer blocks.
module gray2bin_comb #(
   parameter int W = 5
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   for (genvar i = 0; i < W; i++) begin : g_bit
      assign bin_o[i] = ^gray_i[W-1:i];
   end

endmodule

// File: rtl/wptr_full_gray.sv
// Write-side pointer/flag controller: binary counter, registered Gray pointer, full/almost-full/level.
// Define WPTR_OVF_EN to add the sticky overflow flag (wovf_o) and its clear (wovf_clr_i).
module wptr_full_gray
   import fifo_ptr_pkg::*;
#(
   parameter int ASIZE        = 4,
   parameter int AFULL_MARGIN = 2
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             w_en_i,
   input  logic [ASIZE:0]   wq2_rptr_i,
`ifdef WPTR_OVF_EN
   input  logic             wovf_clr_i,
   output logic             wovf_o,
`endif
   output logic [ASIZE-1:0] waddr_o,
   output logic [ASIZE:0]   wptr_o,
   output logic             wfull_o,
   output logic             walmost_full_o,
   output logic [ASIZE:0]   wlevel_o
);

   localparam int unsigned        DEPTH    = fifo_depth(ASIZE);
   localparam logic [ASIZE+1:0]   DEPTH_W  = (ASIZE+2)'(DEPTH);
   localparam logic [ASIZE+1:0]   MARGIN_W = (ASIZE+2)'(AFULL_MARGIN);

   logic [ASIZE:0]   wbin_q, wbin_d;
   logic [ASIZE:0]   wptr_q, wptr_d;
   logic [ASIZE:0]   level_q, level_d;
   logic             wfull_q, wfull_d;
   logic             afull_q, afull_d;
   logic [ASIZE:0]   rbin;
   logic [ASIZE+1:0] free_slots;
   logic             winc;

   gray2bin_comb #(.W(ASIZE+1)) u_rptr_g2b (
      .gray_i (wq2_rptr_i),
      .bin_o  (rbin)
   );

   always_comb begin
      winc       = w_en_i & ~wfull_q;
      wbin_d     = wbin_q + {{ASIZE{1'b0}}, winc};
      wptr_d     = (wbin_d >> 1) ^ wbin_d;
      // Full when the pointers differ only in the two MSBs (one lap apart).
      wfull_d    = (wptr_d == {~wq2_rptr_i[ASIZE:ASIZE-1], wq2_rptr_i[ASIZE-2:0]});
      level_d    = wbin_d - rbin;
      free_slots = DEPTH_W - {1'b0, level_d};
      afull_d    = (free_slots <= MARGIN_W);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         level_q <= '0;
         wfull_q <= 1'b0;
         afull_q <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wptr_d;
         level_q <= level_d;
         wfull_q <= wfull_d;
         afull_q <= afull_d;
      end
   end

`ifdef WPTR_OVF_EN
   logic ovf_q, ovf_d;

   // Set has priority over clear.
   always_comb begin
      ovf_d = ovf_q;
      if (wovf_clr_i)
         ovf_d = 1'b0;
      if (w_en_i & wfull_q)
         ovf_d = 1'b1;
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) ovf_q <= 1'b0;
      else         ovf_q <= ovf_d;
   end

   assign wovf_o = ovf_q;
`endif

   assign waddr_o        = wbin_q[ASIZE-1:0];
   assign wptr_o         = wptr_q;
   assign wfull_o        = wfull_q;
   assign walmost_full_o = afull_q;
   assign wlevel_o       = level_q;

endmodule

// File: tb/tb_wptr_full_gray.sv
// Directed bench for wptr_full_gray at ASIZE=2, DEPTH=4, AFULL_MARGIN=1.
// Define WPTR_OVF_EN to also exercise the sticky overflow flag.
module tb_wptr_full_gray;

   logic       wclk = 1'b0;
   logic       wrst_n = 1'b0;
   logic       w_en = 1'b0;
   logic [2:0] wq2_rptr = '0;
   logic [1:0] waddr;
   logic [2:0] wptr;
   logic       wfull;
   logic       wafull;
   logic [2:0] wlevel;
`ifdef WPTR_OVF_EN
   logic       wovf_clr = 1'b0;
   logic       wovf;
`endif

   int vecs = 0;
   int errs = 0;

   always #5 wclk = ~wclk;

   wptr_full_gray #(.ASIZE(2), .AFULL_MARGIN(1)) dut (
      .wclk           (wclk),
      .wrst_n         (wrst_n),
      .w_en_i         (w_en),
      .wq2_rptr_i     (wq2_rptr),
`ifdef WPTR_OVF_EN
      .wovf_clr_i     (wovf_clr),
      .wovf_o         (wovf),
`endif
      .waddr_o        (waddr),
      .wptr_o         (wptr),
      .wfull_o        (wfull),
      .walmost_full_o (wafull),
      .wlevel_o       (wlevel)
   );

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      w_en = 1'b0;
      wq2_rptr = '0;
`ifdef WPTR_OVF_EN
      wovf_clr = 1'b0;
`endif
      wrst_n = 1'b0;
      tick();
      wrst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      vecs++;
      if ({waddr, wptr, wfull, wafull, wlevel} !== 10'b0) begin
         $display("FAIL reset: got addr=%b ptr=%b full=%b af=%b lvl=%0d, want all 0",
                  waddr, wptr, wfull, wafull, wlevel);
         errs++;
      end
   endtask

   task automatic test_fill();
      logic [2:0] exp_ptr [4] = '{3'b001, 3'b011, 3'b010, 3'b110};
      logic       exp_af  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic       exp_f   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         w_en = 1'b1;
         tick();
         vecs++;
         if (wptr !== exp_ptr[i] || wlevel !== 3'(i+1) || wafull !== exp_af[i] || wfull !== exp_f[i]) begin
            $display("FAIL fill[%0d]: got ptr=%b lvl=%0d af=%b full=%b, want ptr=%b lvl=%0d af=%b full=%b",
                     i, wptr, wlevel, wafull, wfull, exp_ptr[i], i+1, exp_af[i], exp_f[i]);
            errs++;
         end
      end
      w_en = 1'b0;
   endtask

   // Entry: full at wbin=4.
   task automatic test_full_drop();
      w_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vecs++;
         if (wptr !== 3'b110 || waddr !== 2'd0 || wlevel !== 3'd4 || wfull !== 1'b1) begin
            $display("FAIL drop[%0d]: got ptr=%b addr=%0d lvl=%0d full=%b, want 110 0 4 1",
                     i, wptr, waddr, wlevel, wfull);
            errs++;
         end
      end
      w_en = 1'b0;
`ifdef WPTR_OVF_EN
      tick();
      vecs++;
      if (wovf !== 1'b1) begin
         $display("FAIL ovf_set: got %b want 1", wovf); errs++;
      end
      wovf_clr = 1'b1;
      w_en = 1'b1;
      tick();
      vecs++;
      if (wovf !== 1'b1) begin
         $display("FAIL ovf_set_wins: got %b want 1", wovf); errs++;
      end
      w_en = 1'b0;
      tick();
      wovf_clr = 1'b0;
      vecs++;
      if (wovf !== 1'b0) begin
         $display("FAIL ovf_clr: got %b want 0", wovf); errs++;
      end
`endif
   endtask

   task automatic test_free_one();
      wq2_rptr = 3'b001;
      tick();
      vecs++;
      if (wfull !== 1'b0 || wlevel !== 3'd3 || wafull !== 1'b1) begin
         $display("FAIL free: got full=%b lvl=%0d af=%b, want 0 3 1", wfull, wlevel, wafull);
         errs++;
      end
      w_en = 1'b1;
      tick();
      w_en = 1'b0;
      vecs++;
      if (wfull !== 1'b1 || wptr !== 3'b111 || wlevel !== 3'd4) begin
         $display("FAIL refill: got full=%b ptr=%b lvl=%0d, want 1 111 4", wfull, wptr, wlevel);
         errs++;
      end
   endtask

   task automatic test_wrap();
      logic [2:0] exp_ptr [8] = '{3'b001, 3'b011, 3'b010, 3'b110,
                                  3'b111, 3'b101, 3'b100, 3'b000};
      logic [2:0] prev;
      do_reset();
      prev = 3'b000;
      for (int i = 0; i < 8; i++) begin
         w_en = 1'b1;
         tick();
         w_en = 1'b0;
         vecs++;
         if (wptr !== exp_ptr[i] || $countones(wptr ^ prev) != 1 || wfull !== 1'b0 ||
             wlevel !== 3'd1 || waddr !== 2'((i+1) % 4)) begin
            $display("FAIL wrap[%0d]: got ptr=%b prev=%b full=%b lvl=%0d addr=%0d, want ptr=%b full=0 lvl=1 addr=%0d",
                     i, wptr, prev, wfull, wlevel, waddr, exp_ptr[i], (i+1) % 4);
            errs++;
         end
         prev = exp_ptr[i];
         wq2_rptr = exp_ptr[i];
         tick();
         vecs++;
         if (wlevel !== 3'd0 || wfull !== 1'b0) begin
            $display("FAIL wrap_rd[%0d]: got lvl=%0d full=%b, want 0 0", i, wlevel, wfull);
            errs++;
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      w_en = 1'b1;
      tick();
      tick();
      vecs++;
      if (wlevel !== 3'd2 || wafull !== 1'b0) begin
         $display("FAIL b2b_pre: got lvl=%0d af=%b, want 2 0", wlevel, wafull); errs++;
      end
      wq2_rptr = 3'b001;
      tick();
      w_en = 1'b0;
      vecs++;
      if (wlevel !== 3'd2 || wafull !== 1'b0 || wfull !== 1'b0 || wptr !== 3'b010) begin
         $display("FAIL b2b: got lvl=%0d af=%b full=%b ptr=%b, want 2 0 0 010",
                  wlevel, wafull, wfull, wptr);
         errs++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      w_en = 1'b1;
      repeat (3) tick();
      vecs++;
      if (wlevel !== 3'd3 || wafull !== 1'b1) begin
         $display("FAIL ar_pre: got lvl=%0d af=%b, want 3 1", wlevel, wafull); errs++;
      end
      #2;
      wrst_n = 1'b0;
      #1;
      vecs++;
      if ({waddr, wptr, wfull, wafull, wlevel} !== 10'b0) begin
         $display("FAIL async_reset: got addr=%b ptr=%b full=%b af=%b lvl=%0d, want all 0",
                  waddr, wptr, wfull, wafull, wlevel);
         errs++;
      end
      w_en = 1'b0;
      tick();
      wrst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_drop();
      test_free_one();
      test_wrap();
      test_back_to_back();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
